// File: rtl/ber_mer_monitor.sv
// Bit/symbol error monitor: compares received I/Q decisions against a delayed reference,
// finds (or takes) the receiver latency, then counts errors over a fixed symbol window.
module ber_mer_monitor #(
  parameter int unsigned SYM_BITS    = 2,
  parameter int unsigned MAX_DELAY   = 64,
  parameter int unsigned DLY_W       = 6,
  parameter int unsigned WINDOW_LOG2 = 20,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned LOCK_SYMS   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sym_clk_ena,
  input  logic [SYM_BITS-1:0] ref_i,
  input  logic [SYM_BITS-1:0] ref_q,
  input  logic [SYM_BITS-1:0] rx_i,
  input  logic [SYM_BITS-1:0] rx_q,
  input  logic                start,
  input  logic                auto_align,
  input  logic [DLY_W-1:0]    manual_delay,
  input  logic                continuous,
  output logic                busy,
  output logic                locked,
  output logic                align_fail,
  output logic [DLY_W-1:0]    delay_out,
  output logic                done,
  output logic [CNT_W-1:0]    bit_err_count,
  output logic [CNT_W-1:0]    sym_err_count
);

  localparam int unsigned SymW  = 2 * SYM_BITS;
  localparam int unsigned FillW = $clog2(MAX_DELAY + 1);
  localparam int unsigned RunW  = $clog2(LOCK_SYMS + 1);
  localparam int unsigned NbW   = $clog2(SymW + 1);

  typedef enum logic [1:0] {StIdle, StSearch, StMeasure} state_e;

  state_e                 state_q, state_d;
  logic [DLY_W-1:0]       delay_q, delay_d;
  logic                   locked_q, locked_d;
  logic                   fail_q, fail_d;
  logic [RunW-1:0]        run_q, run_d;
  logic [WINDOW_LOG2-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0]       bit_acc_q, bit_acc_d, sym_acc_q, sym_acc_d;
  logic [CNT_W-1:0]       bit_res_q, bit_res_d, sym_res_q, sym_res_d;
  logic                   done_q, done_d;
  logic [FillW-1:0]       fill_q;
  logic [SymW-1:0]        dline_q [MAX_DELAY-1];

  // Delay line and fill counter run in every state so a start can align immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= '0;
      for (int k = 0; k < MAX_DELAY - 1; k++) dline_q[k] <= '0;
    end else if (sym_clk_ena) begin
      if (fill_q != FillW'(MAX_DELAY)) fill_q <= fill_q + 1'b1;
      dline_q[0] <= {ref_i, ref_q};
      for (int k = 1; k < MAX_DELAY - 1; k++) dline_q[k] <= dline_q[k-1];
    end
  end

  // Tap 0 is the live input; taps past the line length alias the oldest entry.
  logic [SymW-1:0] taps [2**DLY_W];
  assign taps[0] = {ref_i, ref_q};
  for (genvar k = 1; k < 2**DLY_W; k++) begin : g_tap
    if (k < MAX_DELAY) begin : g_in
      assign taps[k] = dline_q[k-1];
    end else begin : g_over
      assign taps[k] = dline_q[MAX_DELAY-2];
    end
  end

  logic [SymW-1:0]  diff;
  logic [NbW-1:0]   nbits;
  logic             sym_err;
  logic [CNT_W:0]   bit_sum, sym_sum;
  logic [CNT_W-1:0] bit_next, sym_next;

  always_comb begin
    diff  = taps[delay_q] ^ {rx_i, rx_q};
    nbits = '0;
    for (int i = 0; i < SymW; i++) nbits = nbits + NbW'(diff[i]);
    sym_err  = |diff;
    bit_sum  = {1'b0, bit_acc_q} + (CNT_W+1)'(nbits);
    sym_sum  = {1'b0, sym_acc_q} + (CNT_W+1)'(sym_err);
    bit_next = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    sym_next = sym_sum[CNT_W] ? '1 : sym_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    locked_d  = locked_q;
    fail_d    = fail_q;
    run_d     = run_q;
    sym_cnt_d = sym_cnt_q;
    bit_acc_d = bit_acc_q;
    sym_acc_d = sym_acc_q;
    bit_res_d = bit_res_q;
    sym_res_d = sym_res_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && fill_q == FillW'(MAX_DELAY)) begin
          locked_d  = 1'b0;
          fail_d    = 1'b0;
          run_d     = '0;
          sym_cnt_d = '0;
          bit_acc_d = '0;
          sym_acc_d = '0;
          if (auto_align) begin
            delay_d = '0;
            state_d = StSearch;
          end else begin
            delay_d  = manual_delay;
            locked_d = 1'b1;
            state_d  = StMeasure;
          end
        end
      end
      StSearch: begin
        if (sym_clk_ena) begin
          if (!sym_err) begin
            run_d = run_q + 1'b1;
            if (run_q == RunW'(LOCK_SYMS - 1)) begin
              locked_d = 1'b1;
              state_d  = StMeasure;
            end
          end else begin
            run_d = '0;
            if (delay_q == DLY_W'(MAX_DELAY - 1)) begin
              fail_d  = 1'b1;
              delay_d = '0;
              state_d = StIdle;
            end else begin
              delay_d = delay_q + 1'b1;
            end
          end
        end
      end
      StMeasure: begin
        if (sym_clk_ena) begin
          sym_cnt_d = sym_cnt_q + 1'b1;
          bit_acc_d = bit_next;
          sym_acc_d = sym_next;
          if (&sym_cnt_q) begin
            bit_res_d = bit_next;
            sym_res_d = sym_next;
            done_d    = 1'b1;
            bit_acc_d = '0;
            sym_acc_d = '0;
            sym_cnt_d = '0;
            if (!continuous) state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      delay_q   <= '0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
      run_q     <= '0;
      sym_cnt_q <= '0;
      bit_acc_q <= '0;
      sym_acc_q <= '0;
      bit_res_q <= '0;
      sym_res_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
      run_q     <= run_d;
      sym_cnt_q <= sym_cnt_d;
      bit_acc_q <= bit_acc_d;
      sym_acc_q <= sym_acc_d;
      bit_res_q <= bit_res_d;
      sym_res_q <= sym_res_d;
      done_q    <= done_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign locked        = locked_q;
  assign align_fail    = fail_q;
  assign delay_out     = delay_q;
  assign done          = done_q;
  assign bit_err_count = bit_res_q;
  assign sym_err_count = sym_res_q;

endmodule

// File: tb/tb_ber_mer_monitor.sv
// Scoreboard bench: two monitors (12-bit and 4-bit counters) share stimulus; expected window
// results are queued by the stimulus and checked whenever done pulses.
module tb_ber_mer_monitor;
  localparam int unsigned SB = 2, MD = 16, DW = 4, WL = 8, CW = 12, CWS = 4, LS = 32;

  logic clk = 1'b0;
  logic reset, ena, start, auto_align, continuous;
  logic [SB-1:0] ref_i, ref_q, rx_i, rx_q;
  logic [DW-1:0] manual_delay;
  logic busy_a, locked_a, fail_a, done_a, busy_b, locked_b, fail_b, done_b;
  logic [DW-1:0] delay_a, delay_b;
  logic [CW-1:0] bit_a, sym_a;
  logic [CWS-1:0] bit_b, sym_b;

  always #5 clk = ~clk;

  ber_mer_monitor #(.SYM_BITS(SB), .MAX_DELAY(MD), .DLY_W(DW), .WINDOW_LOG2(WL), .CNT_W(CW),
                    .LOCK_SYMS(LS)) u_dut (
    .clk(clk), .reset(reset), .sym_clk_ena(ena), .ref_i(ref_i), .ref_q(ref_q), .rx_i(rx_i),
    .rx_q(rx_q), .start(start), .auto_align(auto_align), .manual_delay(manual_delay),
    .continuous(continuous), .busy(busy_a), .locked(locked_a), .align_fail(fail_a),
    .delay_out(delay_a), .done(done_a), .bit_err_count(bit_a), .sym_err_count(sym_a));

  ber_mer_monitor #(.SYM_BITS(SB), .MAX_DELAY(MD), .DLY_W(DW), .WINDOW_LOG2(WL), .CNT_W(CWS),
                    .LOCK_SYMS(LS)) u_sat (
    .clk(clk), .reset(reset), .sym_clk_ena(ena), .ref_i(ref_i), .ref_q(ref_q), .rx_i(rx_i),
    .rx_q(rx_q), .start(start), .auto_align(auto_align), .manual_delay(manual_delay),
    .continuous(continuous), .busy(busy_b), .locked(locked_b), .align_fail(fail_b),
    .delay_out(delay_b), .done(done_b), .bit_err_count(bit_b), .sym_err_count(sym_b));

  typedef struct {
    int bit_a; int sym_a; int bit_b; int sym_b; int dly; int busy_after;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, done_seen = 0, sym_total = 0, mode = 0;
  logic [3:0] hist [16];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_a || done_b) begin
      check("done_pair", done_b, done_a);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done pulse, expected no pending window");
      end else begin
        e = q.pop_front();
        check("bit_err_count", bit_a, e.bit_a);
        check("sym_err_count", sym_a, e.sym_a);
        check("bit_err_count_sat", bit_b, e.bit_b);
        check("sym_err_count_sat", sym_b, e.sym_b);
        check("delay_at_done", delay_a, e.dly);
        check("locked_at_done", locked_a, 1);
        check("align_fail_at_done", fail_a, 0);
        check("busy_after_done", busy_a, e.busy_after);
        check("sat_state_match", {busy_b, locked_b, fail_b, delay_b},
              {busy_a, locked_a, fail_a, delay_a});
      end
      done_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One symbol: strobe for one cycle, idle for one, then settle past the sampling edge.
  task automatic sym();
    logic [3:0] r, x;
    tick();
    r = 4'($urandom_range(0, 15));
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = r;
    x = hist[5];
    case (mode)
      1: if (sym_total % 16 == 0) x = x ^ 4'b0100;
      2: x = 4'($urandom_range(0, 15));
      3: x = ~x;
      default: ;
    endcase
    {ref_i, ref_q} = r;
    {rx_i, rx_q} = x;
    ena = 1'b1;
    sym_total++;
    tick();
    ena = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic run_syms(input int n);
    for (int i = 0; i < n; i++) sym();
  endtask

  task automatic pulse_start(input bit aa, input int md);
    tick();
    auto_align = aa;
    manual_delay = 4'(md);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int bound, output int nsyms);
    int target;
    target = done_seen + 1;
    nsyms = 0;
    while (done_seen < target && nsyms < bound) begin
      sym();
      nsyms++;
    end
    if (done_seen < target) begin
      checks++;
      failures++;
      $display("FAIL %s: got no done within %0d symbols, expected done", name, bound);
    end
  endtask

  initial begin
    int n, ds;
    reset = 1'b1; ena = 1'b0; start = 1'b0; auto_align = 1'b0; continuous = 1'b0;
    manual_delay = '0; ref_i = '0; ref_q = '0; rx_i = '0; rx_q = '0;
    for (int k = 0; k < 16; k++) hist[k] = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_locked", locked_a, 0);
    check("rst_align_fail", fail_a, 0);
    check("rst_delay", delay_a, 0);
    check("rst_done", done_a, 0);
    check("rst_bit", bit_a, 0);
    check("rst_sym", sym_a, 0);

    // 1: auto search finds delay 5, clean window
    mode = 0;
    run_syms(20);
    q.push_back('{0, 0, 0, 0, 5, 0});
    pulse_start(1, 0);
    wait_done("t1_window", 1000, n);
    check("t1_busy_idle", busy_a, 0);

    // 2: manual delay, one flipped bit every 16th symbol
    mode = 1;
    q.push_back('{16, 16, 15, 15, 5, 0});
    pulse_start(0, 5);
    wait_done("t2_window", 400, n);
    check("t2_window_len", n, 256);

    // 3: uncorrelated rx -> sweep fails
    mode = 2;
    pulse_start(1, 0);
    n = 0;
    while (busy_a && n < 2000) begin
      sym();
      n++;
    end
    check("t3_search_ended", busy_a, 0);
    check("t3_align_fail", fail_a, 1);
    check("t3_locked", locked_a, 0);
    check("t3_delay", delay_a, 0);
    check("t3_swept_all", n >= 16, 1);
    check("t3_results_held", bit_a, 16);

    // 4: every bit wrong; 4-bit counters saturate
    mode = 3;
    q.push_back('{1024, 256, 15, 15, 5, 0});
    pulse_start(0, 5);
    wait_done("t4_window", 400, n);

    // 5: start before delay line full, then reset mid-window
    mode = 0;
    do_reset();
    check("t5_rst_bit", bit_a, 0);
    check("t5_rst_sym", sym_a, 0);
    check("t5_rst_bit_sat", bit_b, 0);
    run_syms(5);
    pulse_start(0, 5);
    check("t5_early_start_ignored", busy_a, 0);
    run_syms(15);
    pulse_start(0, 5);
    check("t5_start_accepted", busy_a, 1);
    run_syms(50);
    do_reset();
    check("t5_mid_busy", busy_a, 0);
    check("t5_mid_locked", locked_a, 0);
    check("t5_mid_delay", delay_a, 0);
    check("t5_mid_done", done_a, 0);
    ds = done_seen;
    run_syms(300);
    check("t5_no_done", done_seen, ds);

    // 6: continuous windows without re-search
    continuous = 1'b1;
    q.push_back('{0, 0, 0, 0, 5, 1});
    q.push_back('{0, 0, 0, 0, 5, 1});
    q.push_back('{0, 0, 0, 0, 5, 0});
    pulse_start(1, 0);
    wait_done("t6_w1", 1000, n);
    wait_done("t6_w2", 400, n);
    check("t6_w2_len", n, 256);
    continuous = 1'b0;
    wait_done("t6_w3", 400, n);
    check("t6_w3_len", n, 256);
    check("t6_busy_idle", busy_a, 0);

    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
